stride_update_writer: RTL and testbench

Write-side engine for one stage RAM of the 4-bit stride trie lookup pipeline. It accepts one route-update request at a time and applies controlled prefix expansion within a single 16-entry node. Each expanded slot is read-modified-written so that longer prefixes already in the node are never clobbered by shorter ones. It also installs child pointers. The stride lookup stages then read the table it maintains.

---
 rtl/stride_wr_pkg.sv | 20 ++
 rtl/stride_update_writer_expand.sv | 24 ++
 rtl/stride_update_writer.sv | 130 +++++++++++++
 tb/tb_stride_update_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stride_wr_pkg.sv
// stride_wr_pkg: shared widths, entry layout, op codes, FSM states and prefix mask for the stride update writer
package stride_wr_pkg;
  localparam int ADDR_LEN = 12;
  localparam int NH_W = 8;
  localparam int CHILD_LSB = 0;
  localparam int NH_LSB = ADDR_LEN;
  localparam int CV_BIT = ADDR_LEN + NH_W;
  function automatic int entry_w(input int addr_len, input int nh_w);
    return addr_len + nh_w + 1;
  endfunction
  localparam int ENTRY_W = entry_w(ADDR_LEN, NH_W);
  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_CHILD = 1'b1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  function automatic logic [3:0] mask(input logic [2:0] plen);
    logic [7:0] m;
    m = 8'hF0 >> plen;
    return m[3:0];
  endfunction
endpackage

// File: rtl/stride_update_writer_expand.sv
// stride_expand: slot address and last-slot flag for controlled prefix expansion inside one 16-entry node
module stride_expand
  import stride_wr_pkg::*;
(
  input  logic [ADDR_LEN-5:0] i_node,
  input  logic                i_op,
  input  logic [3:0]          i_bits,
  input  logic [2:0]          i_plen,
  input  logic [2:0]          i_k,
  output logic [ADDR_LEN-1:0] o_addr,
  output logic                o_last
);
  logic [3:0] w_mask;
  logic [3:0] w_slot;
  logic [2:0] w_klast;
  // free low bits of the prefix enumerate the slots; child op targets exactly one slot
  always_comb begin
    w_mask = mask(i_plen);
    w_slot = i_op == OP_CHILD ? i_bits : (i_bits & w_mask) | {1'b0, i_k};
    w_klast = i_op == OP_CHILD ? 3'd0 : ~w_mask[2:0];
    o_addr = {i_node, w_slot};
    o_last = i_k == w_klast;
  end
endmodule

// File: rtl/stride_update_writer.sv
// stride_update_writer: read-modify-write route update engine for one stride trie stage RAM (optional STRIDE_WR_STATS_EN adds write/skip counters)
module stride_update_writer
  import stride_wr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [ADDR_LEN-1:0] req_base,
  input  logic [3:0]          req_bits,
  input  logic [2:0]          req_plen,
  input  logic [NH_W-1:0]     req_nexthop,
  input  logic [ADDR_LEN-1:0] req_child,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_rd_en,
  input  logic [ENTRY_W-1:0]  mem_rd_data,
  input  logic [2:0]          mem_rd_len,
  output logic                mem_wr_en,
  output logic [ENTRY_W-1:0]  mem_wr_data,
  output logic [2:0]          mem_wr_len,
  output logic                done,
  output logic                err
`ifdef STRIDE_WR_STATS_EN
  ,
  output logic [15:0]         stat_writes,
  output logic [15:0]         stat_skips
`endif
);
  state_t r_state, w_next;
  logic                r_op;
  logic [ADDR_LEN-5:0] r_node;
  logic [3:0]          r_bits;
  logic [2:0]          r_plen;
  logic [NH_W-1:0]     r_nh;
  logic [ADDR_LEN-1:0] r_child;
  logic [2:0]          r_k;
  logic                r_err;
  logic [ADDR_LEN-1:0] w_addr;
  logic                w_last;
  logic                w_bad;
  logic                w_hit;
  logic                w_unused_base_lsb;
  assign w_unused_base_lsb = ^req_base[3:0];
  assign w_bad = req_op == OP_INSERT && (req_plen == 3'd0 || req_plen > 3'd4);
  stride_expand u_expand (
    .i_node (r_node),
    .i_op   (r_op),
    .i_bits (r_bits),
    .i_plen (r_plen),
    .i_k    (r_k),
    .o_addr (w_addr),
    .o_last (w_last)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // request capture and slot counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op <= 1'b0;
      r_node <= '0;
      r_bits <= '0;
      r_plen <= '0;
      r_nh <= '0;
      r_child <= '0;
      r_k <= '0;
      r_err <= 1'b0;
    end else if (r_state == IDLE && req_valid) begin
      r_op <= req_op;
      r_node <= req_base[ADDR_LEN-1:4];
      r_bits <= req_bits;
      r_plen <= req_plen;
      r_nh <= req_nexthop;
      r_child <= req_child;
      r_k <= '0;
      r_err <= w_bad;
    end else if (r_state == WRITE && !w_last) r_k <= r_k + 3'd1;
  // next state and outputs; a shorter insert never overwrites a longer stored prefix
  always_comb begin
    w_next = r_state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr = '0;
    mem_wr_data = '0;
    mem_wr_len = '0;
    done = 1'b0;
    err = 1'b0;
    w_hit = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        w_next = !req_valid ? IDLE : w_bad ? FIN : READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr = w_addr;
        w_next = WRITE;
      end
      WRITE: begin
        mem_addr = w_addr;
        w_hit = r_op == OP_CHILD || r_plen >= mem_rd_len;
        mem_wr_en = w_hit;
        mem_wr_data = !w_hit ? '0 : r_op == OP_CHILD ? {1'b1, mem_rd_data[NH_LSB +: NH_W], r_child}
                    : {mem_rd_data[CV_BIT], r_nh, mem_rd_data[CHILD_LSB +: ADDR_LEN]};
        mem_wr_len = !w_hit ? 3'd0 : r_op == OP_CHILD ? mem_rd_len : r_plen;
        w_next = w_last ? FIN : READ;
      end
      FIN: begin
        done = 1'b1;
        err = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
`ifdef STRIDE_WR_STATS_EN
  // saturating counts of performed and suppressed slot writes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_writes <= '0;
      stat_skips <= '0;
    end else begin
      if (mem_wr_en && stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
      if (r_state == WRITE && !mem_wr_en && stat_skips != 16'hFFFF) stat_skips <= stat_skips + 16'd1;
    end
`endif
endmodule

// File: tb/tb_stride_update_writer.sv
// tb_stride_update_writer: directed scoreboard bench for stride_update_writer with a 1-cycle-latency RAM model
module tb_stride_update_writer;
  import stride_wr_pkg::*;
  typedef struct {
    logic [11:0] a;
    logic [20:0] d;
    logic [2:0]  l;
  } wr_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [11:0] req_base = '0;
  logic [3:0]  req_bits = '0;
  logic [2:0]  req_plen = '0;
  logic [7:0]  req_nexthop = '0;
  logic [11:0] req_child = '0;
  logic        req_ready, mem_rd_en, mem_wr_en, done, err;
  logic [11:0] mem_addr;
  logic [20:0] mem_rd_data = '0;
  logic [2:0]  mem_rd_len = '0;
  logic [20:0] mem_wr_data;
  logic [2:0]  mem_wr_len;
`ifdef STRIDE_WR_STATS_EN
  logic [15:0] stat_writes, stat_skips;
`endif
  logic [20:0] ram [0:4095] = '{default: '0};
  logic [2:0]  ram_len [0:4095] = '{default: '0};
  logic [20:0] m_data [0:4095] = '{default: '0};
  logic [2:0]  m_len [0:4095] = '{default: '0};
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [20:0] pre_data = '0;
  logic [2:0]  pre_len = '0;
  wr_t q[$];
  int checks = 0, failures = 0, rd_cnt = 0, wr_cnt = 0, exp_w = 0, exp_s = 0;

  stride_update_writer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_bits(req_bits), .req_plen(req_plen), .req_nexthop(req_nexthop),
    .req_child(req_child), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_rd_len(mem_rd_len), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_wr_len(mem_wr_len), .done(done), .err(err)
`ifdef STRIDE_WR_STATS_EN
    , .stat_writes(stat_writes), .stat_skips(stat_skips)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= ram[mem_addr];
      mem_rd_len <= ram_len[mem_addr];
    end
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_wr_data;
      ram_len[mem_addr] <= mem_wr_len;
    end
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
      ram_len[pre_addr] <= pre_len;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    wr_t e;
    @(negedge clk);
    chk("rd_wr_exclusive", mem_rd_en & mem_wr_en, 0);
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      chk("write_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wr_data, e.d);
        chk("wr_len", mem_wr_len, e.l);
      end
    end
  endtask

  task automatic push_model(input logic op, input logic [11:0] base, input logic [3:0] bits,
                            input int plen, input logic [7:0] nh, input logic [11:0] child);
    int n;
    logic [3:0] lo;
    logic [11:0] a;
    logic [20:0] old;
    wr_t e;
    n = op ? 1 : (1 << (4 - plen));
    lo = op ? bits : 4'((bits >> (4 - plen)) << (4 - plen));
    for (int k = 0; k < n; k++) begin
      a = {base[11:4], 4'(lo + k)};
      old = m_data[a];
      e.a = a;
      if (op) begin
        e.d = {1'b1, old[19:12], child};
        e.l = m_len[a];
      end else begin
        e.d = {old[20], nh, old[11:0]};
        e.l = 3'(plen);
      end
      if (op || plen >= int'(m_len[a])) begin
        q.push_back(e);
        m_data[a] = e.d;
        m_len[a] = e.l;
        exp_w++;
      end else exp_s++;
    end
  endtask

  task automatic drive(input logic op, input logic [11:0] base, input logic [3:0] bits,
                       input int plen, input logic [7:0] nh, input logic [11:0] child);
    cycle();
    chk("ready_idle", req_ready, 1);
    req_op = op;
    req_base = base;
    req_bits = bits;
    req_plen = 3'(plen);
    req_nexthop = nh;
    req_child = child;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic do_req(input logic op, input logic [11:0] base, input logic [3:0] bits,
                        input int plen, input logic [7:0] nh, input logic [11:0] child,
                        input int exp_cyc, input logic exp_err);
    int n;
    if (!exp_err) push_model(op, base, bits, plen, nh, child);
    drive(op, base, bits, plen, nh, child);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!done && n < 40);
    chk("done_cycle", n, exp_cyc);
    chk("err_flag", err, exp_err);
    chk("wr_queue_drained", q.size(), 0);
    cycle();
    chk("ready_after_fin", req_ready, 1);
    chk("done_single_pulse", done, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_len", mem_wr_len, 0);
`ifdef STRIDE_WR_STATS_EN
    chk("rst_stat_writes", stat_writes, 0);
    chk("rst_stat_skips", stat_skips, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cycle();
    cycle();
    chk_reset_vals();
    rst = 1'b0;
    do_req(OP_INSERT, 12'h010, 4'b1010, 4, 8'h21, 12'h000, 3, 1'b0);
    chk("t1_ram_data", ram[12'h01A], 21'h021000);
    chk("t1_ram_len", ram_len[12'h01A], 4);
    do_req(OP_INSERT, 12'h020, 4'b1000, 1, 8'h05, 12'h000, 17, 1'b0);
    chk("t2_wr_count", wr_cnt, 8);
    cycle();
    pre_addr = 12'h02B;
    pre_data = 21'h077000;
    pre_len = 3'd3;
    pre_en = 1'b1;
    m_data[12'h02B] = 21'h077000;
    m_len[12'h02B] = 3'd3;
    @(posedge clk);
    #1 pre_en = 1'b0;
    do_req(OP_INSERT, 12'h020, 4'b1000, 2, 8'h09, 12'h000, 9, 1'b0);
    chk("t3_wr_count", wr_cnt, 3);
    chk("t3_skip_kept_data", ram[12'h02B], 21'h077000);
    chk("t3_skip_kept_len", ram_len[12'h02B], 3);
    chk("t3_updated_029", ram[12'h029], 21'h009000);
`ifdef STRIDE_WR_STATS_EN
    chk("t3_stat_skips", stat_skips, 1);
`endif
    do_req(OP_CHILD, 12'h010, 4'b1010, 0, 8'h00, 12'h140, 3, 1'b0);
    chk("t4_child_data", ram[12'h01A], 21'h121140);
    chk("t4_child_len", ram_len[12'h01A], 4);
    do_req(OP_INSERT, 12'h040, 4'b0000, 0, 8'h01, 12'h000, 1, 1'b1);
    chk("plen0_no_rd", rd_cnt, 0);
    chk("plen0_no_wr", wr_cnt, 0);
    do_req(OP_INSERT, 12'h040, 4'b0000, 5, 8'h01, 12'h000, 1, 1'b1);
    chk("plen5_no_rd", rd_cnt, 0);
    chk("plen5_no_wr", wr_cnt, 0);
    push_model(OP_INSERT, 12'h030, 4'b0000, 1, 8'h44, 12'h000);
    drive(OP_INSERT, 12'h030, 4'b0000, 1, 8'h44, 12'h000);
    repeat (5) cycle();
    chk("abort_third_slot_rd", mem_rd_en, 1);
    chk("abort_third_slot_addr", mem_addr, 12'h032);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    chk("abort_pending_writes", q.size(), 6);
    q.delete();
    for (int i = 2; i < 8; i++) begin
      m_data[12'h030 + i] = '0;
      m_len[12'h030 + i] = '0;
    end
    exp_w = 0;
    exp_s = 0;
    cycle();
    rst = 1'b0;
    chk("abort_kept_031", ram[12'h031], 21'h044000);
    chk("abort_untouched_032", ram_len[12'h032], 0);
    do_req(OP_INSERT, 12'h035, 4'b0110, 3, 8'h66, 12'h000, 5, 1'b0);
    chk("t5_ram_036", ram[12'h036], 21'h066000);
    chk("t5_len_037", ram_len[12'h037], 3);
`ifdef STRIDE_WR_STATS_EN
    chk("final_stat_writes", stat_writes, exp_w);
    chk("final_stat_skips", stat_skips, exp_s);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
